pipe_chain_n: RTL and testbench

Parametrised successor to the team's fixed six-stage pipeline model. It has a configurable number of stages, configurable PC and payload widths, and a PC generator with a wrap point and an external redirect. Each stage carries a valid bit, its PC and its payload. Stalls propagate upstream automatically, bubbles are inserted behind a stall, and stall/flush priority is selectable. It sits between instruction fetch and the hazard unit, as the reusable control skeleton for the rv32i core bench.

---
 rtl/pipe_chain_pkg.sv | 32 +++
 rtl/pipe_stage_reg.sv | 77 +++++++
 rtl/pipe_chain_n.sv | 148 ++++++++++++++
 tb/tb_pipe_chain_n.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_chain_pkg.sv
// pipe_chain_pkg
//   Shared types for the parametrised pipeline skeleton.
//   - PIPE_STAGE_T(PW, DW)    : packed stage record {valid, pc, data}. It is
//                               a macro because the widths are parameters of
//                               the modules that use it.
//   - PIPE_STAGE_ZERO(PW, DW) : all-zero stage record (the flush and bubble value).
//   - flush_prio_e            : encoding of the FLUSH_WINS parameter.
//   - hold_bubble()           : bubble-insert condition between two adjacent stages.

`ifndef PIPE_CHAIN_PKG_SV
`define PIPE_CHAIN_PKG_SV

`define PIPE_STAGE_T(PW, DW) struct packed { logic valid; logic [(PW)-1:0] pc; logic [(DW)-1:0] data; }
`define PIPE_STAGE_ZERO(PW, DW) '{valid: 1'b0, pc: {(PW){1'b0}}, data: {(DW){1'b0}}}

package pipe_chain_pkg;

   // Which request wins when a stage sees stall and flush in the same cycle.
   typedef enum logic {
      PRIO_STALL = 1'b0,
      PRIO_FLUSH = 1'b1
   } flush_prio_e;

   // A stage that is not held gets a bubble when the stage feeding it is held.
   // Otherwise the held upstream content would be duplicated downstream.
   function automatic logic hold_bubble(input logic hold_up, input logic hold_here);
      return hold_up & ~hold_here;
   endfunction

endpackage

`endif

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg
//   One pipeline stage register holding valid, pc and payload.
//   Ports:
//     clk, rst                  clock, asynchronous active-high reset
//     hold                      keep the current contents
//     flush                     load the zero record
//     bubble                    load the zero record instead of the source
//                               (only meaningful when not held)
//     src_valid/src_pc/src_data incoming record from the previous stage or fetch
//     valid/pc/data             registered stage contents
//   FLUSH_WINS selects whether hold or flush is checked first.

module pipe_stage_reg
   import pipe_chain_pkg::*;
#(
   parameter int PC_W       = 8,
   parameter int DATA_W     = 16,
   parameter int FLUSH_WINS = 0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              hold,
   input  logic              flush,
   input  logic              bubble,
   input  logic              src_valid,
   input  logic [PC_W-1:0]   src_pc,
   input  logic [DATA_W-1:0] src_data,
   output logic              valid,
   output logic [PC_W-1:0]   pc,
   output logic [DATA_W-1:0] data
);

   typedef `PIPE_STAGE_T(PC_W, DATA_W) stage_t;

   localparam stage_t      STAGE_ZERO = `PIPE_STAGE_ZERO(PC_W, DATA_W);
   localparam flush_prio_e PRIO       = (FLUSH_WINS != 0) ? PRIO_FLUSH : PRIO_STALL;

   stage_t src;
   stage_t load;
   stage_t nxt;
   stage_t q;

   assign src  = '{valid: src_valid, pc: src_pc, data: src_data};
   assign load = bubble ? STAGE_ZERO : src;

   always_comb begin
      nxt = q;
      if (PRIO == PRIO_FLUSH) begin
         if (flush) begin
            nxt = STAGE_ZERO;
         end else if (!hold) begin
            nxt = load;
         end
      end else begin
         if (hold) begin
            nxt = q;
         end else if (flush) begin
            nxt = STAGE_ZERO;
         end else begin
            nxt = load;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         q <= STAGE_ZERO;
      end else begin
         q <= nxt;
      end
   end

   assign valid = q.valid;
   assign pc    = q.pc;
   assign data  = q.data;

endmodule

// File: rtl/pipe_chain_n.sv
// pipe_chain_n
//   Parametrised in-order pipeline control skeleton with a PC generator.
//   Ports:
//     clk, rst          clock, asynchronous active-high reset
//     stall_pc_i        hold the PC
//     stall_i[k]        stall request for stage k; it propagates upstream
//     flush_i[k]        flush request for stage k
//     fetch_valid_i     fetch_data_i (fetched at pc_o) is valid
//     redirect_i        redirect from the REDIRECT_STAGE resolver, with redirect_pc_i
//     pc_o              current PC
//     hold_o            effective per-stage hold (combinational)
//     stage_valid_o     per-stage valid
//     stage_pc_o        stage k at [k*PC_W +: PC_W]
//     stage_data_o      stage k at [k*DATA_W +: DATA_W]
//     retire_valid_o    last stage valid and leaving (combinational)
//     retire_count_o    retired-instruction count, wraps at 2^CNT_W

module pipe_chain_n
   import pipe_chain_pkg::*;
#(
   parameter int STAGES         = 5,
   parameter int PC_W           = 8,
   parameter int DATA_W         = 16,
   parameter int PC_WRAP        = 10,
   parameter int REDIRECT_STAGE = 2,
   parameter int FLUSH_WINS     = 0,
   parameter int CNT_W          = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     stall_pc_i,
   input  logic [STAGES-1:0]        stall_i,
   input  logic [STAGES-1:0]        flush_i,
   input  logic                     fetch_valid_i,
   input  logic [DATA_W-1:0]        fetch_data_i,
   input  logic                     redirect_i,
   input  logic [PC_W-1:0]          redirect_pc_i,
   output logic [PC_W-1:0]          pc_o,
   output logic [STAGES-1:0]        hold_o,
   output logic [STAGES-1:0]        stage_valid_o,
   output logic [STAGES*PC_W-1:0]   stage_pc_o,
   output logic [STAGES*DATA_W-1:0] stage_data_o,
   output logic                     retire_valid_o,
   output logic [CNT_W-1:0]         retire_count_o
);

   localparam logic [PC_W-1:0] PC_WRAP_V = PC_W'(PC_WRAP);

   logic [STAGES-1:0] hold;
   logic [STAGES-1:0] fl;
   logic [STAGES-1:0] bubble;
   logic [STAGES-1:0] valid_q;
   logic [PC_W-1:0]   pc_s   [STAGES];
   logic [DATA_W-1:0] data_s [STAGES];
   logic              redirect_acc;
   logic [PC_W-1:0]   pc_q;
   logic [CNT_W-1:0]  retire_cnt_q;

   // A stall anywhere freezes that stage and everything younger than it.
   always_comb begin
      hold = '0;
      hold[STAGES-1] = stall_i[STAGES-1];
      for (int k = STAGES - 2; k >= 0; k--) begin
         hold[k] = stall_i[k] | hold[k+1];
      end
   end

   // A redirect cannot be taken while its resolving stage is frozen. The
   // requester keeps redirect_i up until it is taken.
   assign redirect_acc = redirect_i & ~hold[REDIRECT_STAGE];

   for (genvar k = 0; k < STAGES; k++) begin : g_stage
      logic              src_valid;
      logic [PC_W-1:0]   src_pc;
      logic [DATA_W-1:0] src_data;

      if (k < REDIRECT_STAGE) begin : g_redir_flush
         assign fl[k] = flush_i[k] | redirect_acc;
      end else begin : g_plain_flush
         assign fl[k] = flush_i[k];
      end

      if (k == 0) begin : g_head
         assign src_valid = fetch_valid_i;
         assign src_pc    = pc_q;
         assign src_data  = fetch_data_i;
         assign bubble[k] = 1'b0;
      end else begin : g_body
         assign src_valid = valid_q[k-1];
         assign src_pc    = pc_s[k-1];
         assign src_data  = data_s[k-1];
         assign bubble[k] = hold_bubble(hold[k-1], hold[k]);
      end

      pipe_stage_reg #(
         .PC_W       (PC_W),
         .DATA_W     (DATA_W),
         .FLUSH_WINS (FLUSH_WINS)
      ) u_stage (
         .clk       (clk),
         .rst       (rst),
         .hold      (hold[k]),
         .flush     (fl[k]),
         .bubble    (bubble[k]),
         .src_valid (src_valid),
         .src_pc    (src_pc),
         .src_data  (src_data),
         .valid     (valid_q[k]),
         .pc        (pc_s[k]),
         .data      (data_s[k])
      );

      assign stage_pc_o[k*PC_W +: PC_W]       = pc_s[k];
      assign stage_data_o[k*DATA_W +: DATA_W] = data_s[k];
   end

   // The redirect target is taken as-is. If it lies above PC_WRAP, the wrap
   // compare never matches and the PC wraps naturally at 2^PC_W.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc_q <= '0;
      end else if (redirect_acc) begin
         pc_q <= redirect_pc_i;
      end else if (stall_pc_i | hold[0]) begin
         pc_q <= pc_q;
      end else if (pc_q == PC_WRAP_V) begin
         pc_q <= '0;
      end else begin
         pc_q <= pc_q + PC_W'(1);
      end
   end

   assign retire_valid_o = valid_q[STAGES-1] & ~hold[STAGES-1];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         retire_cnt_q <= '0;
      end else if (retire_valid_o) begin
         retire_cnt_q <= retire_cnt_q + CNT_W'(1);
      end
   end

   assign pc_o           = pc_q;
   assign hold_o         = hold;
   assign stage_valid_o  = valid_q;
   assign retire_count_o = retire_cnt_q;

endmodule

// File: tb/tb_pipe_chain_n.sv
// tb_pipe_chain_n
//   Directed bench for pipe_chain_n. Two instances share one stimulus:
//   dut_a uses the defaults (stall wins, 16-bit counter), and dut_b uses
//   flush-wins with a 4-bit retire counter. Expected values are worked out
//   by hand from the cycle-by-cycle pipeline contents.

module tb_pipe_chain_n;

   localparam int STAGES = 5;
   localparam int PC_W   = 8;
   localparam int DATA_W = 16;

   logic                     clk = 1'b0;
   logic                     rst;
   logic                     stall_pc_i;
   logic [STAGES-1:0]        stall_i;
   logic [STAGES-1:0]        flush_i;
   logic                     fetch_valid_i;
   logic [DATA_W-1:0]        fetch_data_i;
   logic                     redirect_i;
   logic [PC_W-1:0]          redirect_pc_i;

   logic [PC_W-1:0]          pc_a,    pc_b;
   logic [STAGES-1:0]        hold_a,  hold_b;
   logic [STAGES-1:0]        valid_a, valid_b;
   logic [STAGES*PC_W-1:0]   spc_a,   spc_b;
   logic [STAGES*DATA_W-1:0] sdat_a,  sdat_b;
   logic                     rv_a,    rv_b;
   logic [15:0]              cnt_a;
   logic [3:0]               cnt_b;

   int total  = 0;
   int passed = 0;
   int failed = 0;

   always #5 clk = ~clk;

   pipe_chain_n dut_a (
      .clk            (clk),
      .rst            (rst),
      .stall_pc_i     (stall_pc_i),
      .stall_i        (stall_i),
      .flush_i        (flush_i),
      .fetch_valid_i  (fetch_valid_i),
      .fetch_data_i   (fetch_data_i),
      .redirect_i     (redirect_i),
      .redirect_pc_i  (redirect_pc_i),
      .pc_o           (pc_a),
      .hold_o         (hold_a),
      .stage_valid_o  (valid_a),
      .stage_pc_o     (spc_a),
      .stage_data_o   (sdat_a),
      .retire_valid_o (rv_a),
      .retire_count_o (cnt_a)
   );

   pipe_chain_n #(
      .FLUSH_WINS (1),
      .CNT_W      (4)
   ) dut_b (
      .clk            (clk),
      .rst            (rst),
      .stall_pc_i     (stall_pc_i),
      .stall_i        (stall_i),
      .flush_i        (flush_i),
      .fetch_valid_i  (fetch_valid_i),
      .fetch_data_i   (fetch_data_i),
      .redirect_i     (redirect_i),
      .redirect_pc_i  (redirect_pc_i),
      .pc_o           (pc_b),
      .hold_o         (hold_b),
      .stage_valid_o  (valid_b),
      .stage_pc_o     (spc_b),
      .stage_data_o   (sdat_b),
      .retire_valid_o (rv_b),
      .retire_count_o (cnt_b)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         failed++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] pc_of(input logic [STAGES*PC_W-1:0] v, input int k);
      return 32'(v[k*PC_W +: PC_W]);
   endfunction

   function automatic logic [31:0] data_of(input logic [STAGES*DATA_W-1:0] v, input int k);
      return 32'(v[k*DATA_W +: DATA_W]);
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Payload fetched at the current PC is pc + 0x10.
   task automatic refresh_fetch();
      fetch_data_i = 16'(pc_a) + 16'h0010;
   endtask

   initial begin
      rst           = 1'b1;
      stall_pc_i    = 1'b0;
      stall_i       = '0;
      flush_i       = '0;
      fetch_valid_i = 1'b1;
      fetch_data_i  = 16'h0010;
      redirect_i    = 1'b0;
      redirect_pc_i = '0;

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      chk("rst_pc",    32'(pc_a),    0);
      chk("rst_valid", 32'(valid_a), 0);
      chk("rst_cnt",   32'(cnt_a),   0);
      chk("rst_hold",  32'(hold_a),  0);
      chk("rst_rv",    32'(rv_a),    0);
      rst = 1'b0;
      refresh_fetch();

      // Free run: after edge n, pc = n mod 11 and stage j holds pc (n-1-j) mod 11.
      for (int n = 1; n <= 12; n++) begin
         tick();
         chk("free_pc", 32'(pc_a), 32'(n % 11));
         if (n == 1) begin
            chk("free_s0_valid", 32'(valid_a[0]), 1);
            chk("free_s0_pc",    pc_of(spc_a, 0), 0);
            chk("free_s0_data",  data_of(sdat_a, 0), 'h10);
         end
         if (n == 5) begin
            chk("free_s4_valid", 32'(valid_a[4]), 1);
            chk("free_s4_pc",    pc_of(spc_a, 4), 0);
            chk("free_s4_data",  data_of(sdat_a, 4), 'h10);
         end
         if (n == 12) begin
            chk("free_cnt",  32'(cnt_a), 7);
            chk("free_pc_b", 32'(pc_b),  1);
         end
         refresh_fetch();
      end

      // Stall on stage 2 for three cycles. Pipeline is s0..s4 = 0,10,9,8,7 and pc = 1.
      stall_i = 5'b00100;
      #1;
      chk("stall_hold", 32'(hold_a), 'b00111);
      tick(); refresh_fetch();
      chk("stall1_pc",    32'(pc_a), 1);
      chk("stall1_s2",    pc_of(spc_a, 2), 9);
      chk("stall1_s3_v",  32'(valid_a[3]), 0);
      chk("stall1_s4_pc", pc_of(spc_a, 4), 8);
      chk("stall1_rv",    32'(rv_a), 1);
      tick(); refresh_fetch();
      chk("stall2_pc",   32'(pc_a), 1);
      chk("stall2_s0",   pc_of(spc_a, 0), 0);
      chk("stall2_s3_v", 32'(valid_a[3]), 0);
      chk("stall2_rv",   32'(rv_a), 0);
      tick(); refresh_fetch();
      chk("stall3_pc",   32'(pc_a), 1);
      chk("stall3_s1",   pc_of(spc_a, 1), 10);
      chk("stall3_s3_v", 32'(valid_a[3]), 0);
      stall_i = '0;
      tick(); refresh_fetch();
      chk("rel_pc",      32'(pc_a), 2);
      chk("rel_s0_pc",   pc_of(spc_a, 0), 1);
      chk("rel_s0_data", data_of(sdat_a, 0), 'h11);
      chk("rel_s3_pc",   pc_of(spc_a, 3), 9);
      chk("rel_s4_v",    32'(valid_a[4]), 0);

      // Advance until stage 2 holds pc 3.
      repeat (4) begin
         tick(); refresh_fetch();
      end
      chk("pre_redir_s2", pc_of(spc_a, 2), 3);

      // Redirect accepted immediately.
      redirect_i    = 1'b1;
      redirect_pc_i = 8'h07;
      tick();
      redirect_i = 1'b0;
      refresh_fetch();
      chk("redir_pc",    32'(pc_a), 7);
      chk("redir_s0_v",  32'(valid_a[0]), 0);
      chk("redir_s1_v",  32'(valid_a[1]), 0);
      chk("redir_s1_pc", pc_of(spc_a, 1), 0);
      chk("redir_s2_pc", pc_of(spc_a, 2), 4);
      chk("redir_s3_pc", pc_of(spc_a, 3), 3);

      // Redirect blocked while stage 3 stalls (which holds stage 2).
      redirect_i    = 1'b1;
      redirect_pc_i = 8'hFE;
      stall_i       = 5'b01000;
      #1;
      chk("blk_hold", 32'(hold_a), 'b01111);
      tick(); refresh_fetch();
      chk("blk_pc",   32'(pc_a), 7);
      chk("blk_s2",   pc_of(spc_a, 2), 4);
      chk("blk_s4_v", 32'(valid_a[4]), 0);
      stall_i = '0;
      tick();
      redirect_i = 1'b0;
      refresh_fetch();
      chk("blk_acc_pc", 32'(pc_a), 'hFE);
      chk("blk_acc_s1", 32'(valid_a[1]), 0);
      chk("blk_acc_s3", pc_of(spc_a, 3), 4);
      chk("blk_acc_s4", pc_of(spc_a, 4), 3);

      // Redirect target above PC_WRAP wraps at 2^PC_W.
      tick(); refresh_fetch();
      chk("wrap_pc_ff",   32'(pc_a), 'hFF);
      chk("wrap_s0_pc",   pc_of(spc_a, 0), 'hFE);
      chk("wrap_s0_data", data_of(sdat_a, 0), 'h10E);
      tick(); refresh_fetch();
      chk("wrap_pc_00", 32'(pc_a), 0);
      chk("wrap_s1_pc", pc_of(spc_a, 1), 'hFE);

      // Stall and flush together on stage 1.
      stall_i = 5'b00010;
      flush_i = 5'b00010;
      #1;
      chk("prio_hold", 32'(hold_a), 'b00011);
      for (int c = 0; c < 2; c++) begin
         tick(); refresh_fetch();
         chk("prio_a_s1_v",  32'(valid_a[1]), 1);
         chk("prio_a_s1_pc", pc_of(spc_a, 1), 'hFE);
         chk("prio_b_s1_v",  32'(valid_b[1]), 0);
         chk("prio_b_s1_pc", pc_of(spc_b, 1), 0);
         chk("prio_b_s0_pc", pc_of(spc_b, 0), 'hFF);
         chk("prio_pc_b",    32'(pc_b), 0);
      end
      stall_i = '0;
      flush_i = '0;

      // Fill the pipe, then reset asynchronously mid-cycle.
      repeat (5) begin
         tick(); refresh_fetch();
      end
      chk("fill_valid", 32'(valid_a), 'b11111);
      #2;
      rst = 1'b1;
      #1;
      chk("amid_pc",    32'(pc_a),    0);
      chk("amid_valid", 32'(valid_a), 0);
      chk("amid_spc",   32'(spc_a != '0), 0);
      chk("amid_sdat",  32'(sdat_a != '0), 0);
      chk("amid_cnt",   32'(cnt_a),   0);
      chk("amid_rv",    32'(rv_a),    0);
      chk("amid_valid_b", 32'(valid_b), 0);
      #1;
      rst = 1'b0;
      refresh_fetch();

      // Retire counting after reset: count = n - 5 after edge n.
      for (int n = 1; n <= 25; n++) begin
         tick();
         if (n == 1) begin
            chk("post_rst_s0_v",  32'(valid_a[0]), 1);
            chk("post_rst_s0_pc", pc_of(spc_a, 0), 0);
         end
         if (n == 20) begin
            chk("cnt_a_15", 32'(cnt_a), 15);
            chk("cnt_b_15", 32'(cnt_b), 15);
         end
         if (n == 21) begin
            chk("cnt_b_wrap", 32'(cnt_b), 0);
         end
         if (n == 25) begin
            chk("cnt_a_20", 32'(cnt_a), 20);
            chk("cnt_b_4",  32'(cnt_b), 4);
         end
         refresh_fetch();
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
